// File: rtl/video_mem_write_scheduler.sv
// Write-port scheduler for the 80x60x3 video memory.
// CPU single-cell writes always win; a rectangle-fill engine issues one cell per free cycle
// in raster order. All write-port outputs are registered (1-cycle latency).
// Optional feature: define FILL_ABORT_EN to add the iFillAbort input.
module video_mem_write_scheduler #(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 60,
    parameter int unsigned COL_W   = 7,
    parameter int unsigned ROW_W   = 6,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iCpuWriteReq,
    input  logic [COL_W-1:0]   iCpuCol,
    input  logic [ROW_W-1:0]   iCpuRow,
    input  logic [COLOR_W-1:0] iCpuColor,
    input  logic               iFillStart,
    input  logic [COL_W-1:0]   iFillCol0,
    input  logic [ROW_W-1:0]   iFillRow0,
    input  logic [COL_W-1:0]   iFillCol1,
    input  logic [ROW_W-1:0]   iFillRow1,
    input  logic [COLOR_W-1:0] iFillColor,
`ifdef FILL_ABORT_EN
    input  logic               iFillAbort,
`endif
    output logic               oFillBusy,
    output logic               oFillDone,
    output logic               oWriteEnable,
    output logic [15:0]        oWriteAddress,
    output logic [COLOR_W-1:0] oWriteData
);

    localparam logic [COL_W-1:0] ColMax = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] RowMax = ROW_W'(ROWS - 1);
    localparam int unsigned      PadW   = 16 - COL_W - ROW_W;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e state_q, state_d;

    logic [COL_W-1:0]   cur_col_q, cur_col_d;
    logic [ROW_W-1:0]   cur_row_q, cur_row_d;
    logic [COL_W-1:0]   col0_q, col0_d;
    logic [COL_W-1:0]   col1_q, col1_d;
    logic [ROW_W-1:0]   row1_q, row1_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;

    logic               abort;
    logic               fill_issue;
    logic               fill_last;
    logic               fill_accept;
    logic               fill_empty;
    logic [COL_W-1:0]   c0_clamp, c1_clamp, cpu_col_clamp;
    logic [ROW_W-1:0]   r0_clamp, r1_clamp, cpu_row_clamp;

`ifdef FILL_ABORT_EN
    assign abort = iFillAbort;
`else
    assign abort = 1'b0;
`endif

    // Clamp all incoming coordinates to the visible area and classify the requested rectangle.
    always_comb begin
        c0_clamp      = (iFillCol0 > ColMax) ? ColMax : iFillCol0;
        c1_clamp      = (iFillCol1 > ColMax) ? ColMax : iFillCol1;
        r0_clamp      = (iFillRow0 > RowMax) ? RowMax : iFillRow0;
        r1_clamp      = (iFillRow1 > RowMax) ? RowMax : iFillRow1;
        cpu_col_clamp = (iCpuCol > ColMax) ? ColMax : iCpuCol;
        cpu_row_clamp = (iCpuRow > RowMax) ? RowMax : iCpuRow;
        fill_empty    = (c0_clamp > c1_clamp) || (r0_clamp > r1_clamp);
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (iFillStart) begin
                    state_d = fill_empty ? StDone : StFill;
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (fill_issue && fill_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: status flags and the fill-slot decision (CPU steals the slot).
    always_comb begin
        oFillBusy   = (state_q != StIdle);
        oFillDone   = (state_q == StDone);
        fill_accept = (state_q == StIdle) && iFillStart;
        fill_issue  = (state_q == StFill) && !iCpuWriteReq && !abort;
        fill_last   = (cur_col_q == col1_q) && (cur_row_q == row1_q);
    end

    // Datapath next state: fill counters, latched bounds and the write-port registers.
    always_comb begin
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        col0_d    = col0_q;
        col1_d    = col1_q;
        row1_d    = row1_q;
        color_d   = color_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        if (fill_accept) begin
            cur_col_d = c0_clamp;
            cur_row_d = r0_clamp;
            col0_d    = c0_clamp;
            col1_d    = c1_clamp;
            row1_d    = r1_clamp;
            color_d   = iFillColor;
        end

        if (iCpuWriteReq) begin
            we_d   = 1'b1;
            addr_d = {{PadW{1'b0}}, cpu_col_clamp, cpu_row_clamp};
            data_d = iCpuColor;
        end else if (fill_issue) begin
            we_d   = 1'b1;
            addr_d = {{PadW{1'b0}}, cur_col_q, cur_row_q};
            data_d = color_q;
        end

        // Column-first raster advance; the final pixel leaves the counters in place.
        if (fill_issue && !fill_last) begin
            if (cur_col_q == col1_q) begin
                cur_col_d = col0_q;
                cur_row_d = cur_row_q + 1'b1;
            end else begin
                cur_col_d = cur_col_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur_col_q <= '0;
            cur_row_q <= '0;
            col0_q    <= '0;
            col1_q    <= '0;
            row1_q    <= '0;
            color_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            col0_q    <= col0_d;
            col1_q    <= col1_d;
            row1_q    <= row1_d;
            color_q   <= color_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oWriteData    = data_q;

endmodule
